// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared types, defaults and helpers for the switch
// debounce controller (sw_debounce_ctrl and sw_debounce_cell).
//   evt_state_e  - event presenter FSM states (IDLE, PRESENT)
//   DEF_*        - default parameter values for the controller
//   clog2()      - ceiling log2, never smaller than 1 so it can size ports
package sw_debounce_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } evt_state_e;

    localparam int DEF_N_SW         = 10;
    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_TICK_HZ      = 1000;
    localparam int DEF_STABLE_TICKS = 20;

    // Minimum of 1 keeps a one-switch build from creating a zero-width index.
    function automatic int clog2(input int value);
        int w;
        for (w = 1; (1 << w) < value; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_debounce_cell.sv
// sw_debounce_cell: one switch lane of the debounce controller.
//   clk, rst  - system clock, synchronous active-high reset
//   tick      - sample-tick pulse; the lane state only moves on a tick
//   sw_raw    - raw asynchronous switch level
//   sw_d      - debounced level
//   set_rise  - one-cycle strobe: debounced level just went 0->1
//   set_fall  - one-cycle strobe: debounced level just went 1->0
//               (port exists only when SWDB_FALL_EVENT_EN is defined)
// The strobes are combinational and coincide with the tick edge that
// updates sw_d, so the parent sets its pending bit on that same edge.
module sw_debounce_cell
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw_raw,
    output logic sw_d,
    output logic set_rise
`ifdef SWDB_FALL_EVENT_EN
    ,
    output logic set_fall
`endif
);

    localparam int              CW       = clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;
    logic          differs;
    logic          accept;

    assign differs  = sync_q2 ^ sw_d;
    // The counter tops out at STABLE_TICKS-1: the next differing sample is
    // the accepting one, so the counter never wraps.
    assign accept   = tick & differs & (cnt == CNT_LAST);
    assign set_rise = accept & sync_q2;
`ifdef SWDB_FALL_EVENT_EN
    assign set_fall = accept & ~sync_q2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            sw_d    <= 1'b0;
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
            if (tick) begin
                if (!differs) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    sw_d <= sync_q2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sw_debounce_ctrl.sv
// sw_debounce_ctrl: debounce controller and event scheduler for N_SW slide
// switches.
//   clk, rst    - system clock, synchronous active-high reset
//   iSW         - raw asynchronous switch levels
//   oSW_d       - debounced switch levels
//   oTick       - one-cycle sample tick, every CLK_HZ/TICK_HZ cycles
//   oEvt_valid  - an event is presented
//   iEvt_ready  - consumer accepts the presented event
//   oEvt_idx    - switch index of the presented event
//   oEvt_rise   - 1 = rising edge, 0 = falling edge
//   oOvf        - sticky: an edge was coalesced into a still-pending one
// Build option SWDB_FALL_EVENT_EN: when defined, falling debounced edges are
// queued and reported too; otherwise only rising edges are reported and
// oEvt_rise is tied to 1 (oSW_d tracks both directions either way).
//
// Handshake: oEvt_valid rises only from IDLE; while valid && !ready the
// index/direction hold still; the event transfers on a clock edge where
// valid && ready, valid drops on the next cycle, and the FSM needs one IDLE
// cycle before presenting again (at most one event per two cycles).
module sw_debounce_ctrl
    import sw_debounce_pkg::*;
#(
    parameter int N_SW         = DEF_N_SW,
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int TICK_HZ      = DEF_TICK_HZ,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SW-1:0]          iSW,
    output logic [N_SW-1:0]          oSW_d,
    output logic                     oTick,
    output logic                     oEvt_valid,
    input  logic                     iEvt_ready,
    output logic [clog2(N_SW)-1:0]   oEvt_idx,
    output logic                     oEvt_rise,
    output logic                     oOvf
);

    localparam int IDXW = clog2(N_SW);
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PW   = clog2(DIV);

    // Prescaler: 0..DIV-1, tick during the last count.
    logic [PW-1:0] pcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (pcnt == PW'(DIV - 1)) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign oTick = (pcnt == PW'(DIV - 1));

    // Per-switch lanes.
    logic [N_SW-1:0] set_rise_v;
`ifdef SWDB_FALL_EVENT_EN
    logic [N_SW-1:0] set_fall_v;
`endif

    for (genvar g = 0; g < N_SW; g++) begin : g_cell
        sw_debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .tick     (oTick),
            .sw_raw   (iSW[g]),
            .sw_d     (oSW_d[g]),
            .set_rise (set_rise_v[g])
`ifdef SWDB_FALL_EVENT_EN
            ,
            .set_fall (set_fall_v[g])
`endif
        );
    end

    // Pending bits, arbiter and presenter FSM.
    evt_state_e      state, state_nx;
    logic [N_SW-1:0] pend_rise, pend_rise_nx, clr_rise;
    logic [N_SW-1:0] pend_any, sel;
    logic [IDXW-1:0] pick, idx_nx;
    logic            take;
    logic            ovf_nx;
`ifdef SWDB_FALL_EVENT_EN
    logic [N_SW-1:0] pend_fall, pend_fall_nx, clr_fall;
    logic            evt_rise_q, rise_nx;
`endif

    always_comb begin
        pend_any = pend_rise;
`ifdef SWDB_FALL_EVENT_EN
        pend_any = pend_rise | pend_fall;
`endif
        // Isolate the lowest set bit: x & -x.
        sel  = pend_any & (~pend_any + N_SW'(1));
        pick = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (sel[i]) pick = IDXW'(i);
        end

        state_nx = state;
        idx_nx   = oEvt_idx;
        take     = 1'b0;
        case (state)
            IDLE: begin
                if (|pend_any) begin
                    take     = 1'b1;
                    idx_nx   = pick;
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                if (iEvt_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // A set landing on the bit being cleared wins, so nothing is lost;
        // a set landing on a bit that stays pending is coalesced -> overflow.
        clr_rise     = take ? (sel & pend_rise) : '0;
        pend_rise_nx = (pend_rise & ~clr_rise) | set_rise_v;
        ovf_nx       = oOvf | (|(set_rise_v & pend_rise & ~clr_rise));
`ifdef SWDB_FALL_EVENT_EN
        // Rise has priority when both directions are pending on one switch.
        rise_nx      = take ? (|(sel & pend_rise)) : evt_rise_q;
        clr_fall     = take ? (sel & ~pend_rise) : '0;
        pend_fall_nx = (pend_fall & ~clr_fall) | set_fall_v;
        ovf_nx       = ovf_nx | (|(set_fall_v & pend_fall & ~clr_fall));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            oEvt_idx   <= '0;
            pend_rise  <= '0;
            oOvf       <= 1'b0;
`ifdef SWDB_FALL_EVENT_EN
            pend_fall  <= '0;
            evt_rise_q <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            oEvt_idx   <= idx_nx;
            pend_rise  <= pend_rise_nx;
            oOvf       <= ovf_nx;
`ifdef SWDB_FALL_EVENT_EN
            pend_fall  <= pend_fall_nx;
            evt_rise_q <= rise_nx;
`endif
        end
    end

    assign oEvt_valid = (state == PRESENT);
`ifdef SWDB_FALL_EVENT_EN
    assign oEvt_rise  = evt_rise_q;
`else
    assign oEvt_rise  = 1'b1;
`endif

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// tb_sw_debounce_ctrl: self-checking bench for sw_debounce_ctrl with
// N_SW=10, CLK_HZ=100, TICK_HZ=10 (DIV=10), STABLE_TICKS=3.
// Honours SWDB_FALL_EVENT_EN in its expectations.
module tb_sw_debounce_ctrl;

    localparam int N   = 10;
    localparam int DIV = 10;
    localparam int ST  = 3;

    // Clock / reset
    logic         clk;
    logic         rst;
    logic [N-1:0] sw;
    logic [N-1:0] swd;
    logic         tick;
    logic         evt_valid;
    logic         evt_ready;
    logic [3:0]   evt_idx;
    logic         evt_rise;
    logic         ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sw_debounce_ctrl #(
        .N_SW         (N),
        .CLK_HZ       (100),
        .TICK_HZ      (10),
        .STABLE_TICKS (ST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iSW        (sw),
        .oSW_d      (swd),
        .oTick      (tick),
        .oEvt_valid (evt_valid),
        .iEvt_ready (evt_ready),
        .oEvt_idx   (evt_idx),
        .oEvt_rise  (evt_rise),
        .oOvf       (ovf)
    );

`ifdef SWDB_FALL_EVENT_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the debounced level flips once the last ST tick
    // samples (each the pin value two clocks before the tick) all disagree
    // with it. Ticks fall on every DIV-th rising edge after reset.
    logic [N-1:0] mdl_lvl;
    logic [N-1:0] p1, p2;
    bit           win_q [N][$];
    int           mdl_n;
    int           out_rise [N];
    int           out_fall [N];
    bit           sb_on  = 1'b0;
    bit           chk_lvl = 1'b0;
    int           valid_cycles;
    logic [4:0]   acc_q[$];
    logic [4:0]   exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            mdl_n   = 0;
            p1      = '0;
            p2      = '0;
            mdl_lvl = '0;
            for (int i = 0; i < N; i++) begin
                win_q[i].delete();
                out_rise[i] = 0;
                out_fall[i] = 0;
            end
        end else begin
            if (evt_valid) valid_cycles++;
            if (evt_valid && evt_ready) begin
                acc_q.push_back({evt_idx, evt_rise});
                if (sb_on) begin
                    check("sb_idx_range", evt_idx < N, 1);
                    if (evt_idx < N) begin
                        if (evt_rise) begin
                            check("sb_rise_expected", out_rise[evt_idx] > 0, 1);
                            if (out_rise[evt_idx] > 0) out_rise[evt_idx]--;
                        end else begin
                            check("sb_fall_expected", out_fall[evt_idx] > 0, 1);
                            if (out_fall[evt_idx] > 0) out_fall[evt_idx]--;
                        end
                    end
                end
            end
            mdl_n++;
            if (mdl_n % DIV == 0) begin
                for (int i = 0; i < N; i++) begin
                    bit all_diff;
                    win_q[i].push_back(p2[i]);
                    if (win_q[i].size() > ST) void'(win_q[i].pop_front());
                    all_diff = (win_q[i].size() == ST);
                    foreach (win_q[i][k]) if (win_q[i][k] == mdl_lvl[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        mdl_lvl[i] = ~mdl_lvl[i];
                        if (mdl_lvl[i]) out_rise[i]++;
                        else if (FALL_EN) out_fall[i]++;
                    end
                end
            end
            p2 = p1;
            p1 = sw;
        end
    end

    always @(negedge clk) begin
        if (chk_lvl) check("swd_vs_model", swd, mdl_lvl);
    end

    // Driver tasks (all driving happens on the falling edge)
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic align_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 25 && !seen; k++) begin
            @(negedge clk);
            if (tick) seen = 1'b1;
        end
        check("align_tick_timeout", seen, 1);
    endtask

    // Drive switch idx to val right as a tick is showing, then count the
    // ticks until the debounced level follows (-1 if it never does).
    task automatic set_and_count(input int idx, input logic val, output int ticks);
        bit done;
        align_tick();
        sw[idx] = val;
        ticks = 0;
        done  = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (swd[idx] === val) done = 1'b1;
            else if (tick) ticks++;
        end
        if (!done) ticks = -1;
    endtask

    task automatic expect_events(input string name);
        check({name, "_count"}, acc_q.size(), exp_q.size());
        while (exp_q.size() > 0 && acc_q.size() > 0)
            check(name, acc_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        acc_q.delete();
    endtask

    typedef struct {
        logic [N-1:0] sw;
        int           hold;
        logic [N-1:0] exp_swd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int t;
        int tick_at[$];
        bit bad;
        bit seen;
        int sum;

        vecs[0] = '{10'h000, 45, 10'h000};
        vecs[1] = '{10'h0F0, 45, 10'h0F0};
        vecs[2] = '{10'h3FF, 15, 10'h0F0};   // 15-cycle glitch is too short
        vecs[3] = '{10'h0F0, 45, 10'h0F0};
        vecs[4] = '{10'h30F, 45, 10'h30F};
        vecs[5] = '{10'h000, 45, 10'h000};

        rst = 1'b1;
        sw = '0;
        evt_ready = 1'b0;
        valid_cycles = 0;

        // 1. Reset values and tick cadence
        repeat (3) @(negedge clk);
        chk_lvl = 1'b1;
        check("rst_swd", swd, 0);
        check("rst_tick", tick, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_idx", evt_idx, 0);
        check("rst_rise", evt_rise, FALL_EN ? 0 : 1);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        // Tick occupies the 10th cycle after rst falls: the window between
        // rising edges 9 and 10, i.e. sampled at falling edges 9, 19, 29.
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            if (tick) tick_at.push_back(c);
        end
        check("tick_count", tick_at.size(), 3);
        if (tick_at.size() == 3) begin
            check("tick_first", tick_at[0], 9);
            check("tick_second", tick_at[1], 19);
            check("tick_third", tick_at[2], 29);
        end

        // 2. Clean press of switch 3
        sb_on = 1'b1;
        evt_ready = 1'b1;
        acc_q.delete();
        valid_cycles = 0;
        set_and_count(3, 1'b1, t);
        check("press_ticks", t, ST);
        cyc(6);
        exp_q.push_back({4'd3, 1'b1});
        expect_events("press_evt");
        check("press_valid_cycles", valid_cycles, 1);

        // 3. Bouncing switch 5
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sw[5] = ~sw[5];
            repeat (15) begin
                @(negedge clk);
                if (swd[5] !== 1'b0) bad = 1'b1;
            end
        end
        check("bounce_level_held", bad, 0);
        check("bounce_no_event", acc_q.size(), 0);
        set_and_count(5, 1'b1, t);
        check("bounce_settle_ticks", t, ST);
        cyc(6);
        exp_q.push_back({4'd5, 1'b1});
        expect_events("bounce_evt");

        // 4. Arbitration and hold under back-pressure
        evt_ready = 1'b0;
        sw[7] = 1'b1;
        sw[2] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            if (evt_valid) seen = 1'b1;
        end
        check("arb_valid_timeout", seen, 1);
        check("arb_first_idx", evt_idx, 2);
        check("arb_first_rise", evt_rise, 1);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (evt_valid !== 1'b1 || evt_idx !== 4'd2 || evt_rise !== 1'b1) bad = 1'b1;
        end
        check("arb_hold_stable", bad, 0);
        evt_ready = 1'b1;
        @(negedge clk);
        check("arb_valid_drop", evt_valid, 0);
        @(negedge clk);
        check("arb_second_valid", evt_valid, 1);
        check("arb_second_idx", evt_idx, 7);
        cyc(4);
        exp_q.push_back({4'd2, 1'b1});
        exp_q.push_back({4'd7, 1'b1});
        expect_events("arb_evt");

        // 5. Release of switch 3
        set_and_count(3, 1'b0, t);
        check("release_ticks", t, ST);
        cyc(6);
        if (FALL_EN) exp_q.push_back({4'd3, 1'b0});
        expect_events("release_evt");

        // 6. Overflow with the consumer stalled
        sb_on = 1'b0;
        sw = '0;
        evt_ready = 1'b0;
        do_reset(2);
        sw[1] = 1'b1; cyc(40);
        sw[1] = 1'b0; cyc(40);
        sw[1] = 1'b1; cyc(40);
        check("ovf_first_valid", evt_valid, 1);
        check("ovf_first_idx", evt_idx, 1);
        if (FALL_EN) begin
            check("ovf_not_yet", ovf, 0);
            sw[1] = 1'b0; cyc(40);
            check("ovf_set", ovf, 1);
            sw[1] = 1'b1;
        end else begin
            sw[1] = 1'b0; cyc(40);
            check("ovf_not_yet", ovf, 0);
            sw[1] = 1'b1; cyc(40);
            check("ovf_set", ovf, 1);
        end
        // One-cycle reset clears the flag and drops the stalled event;
        // switch 1 is high through reset, so it reports a rise later.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ovf_cleared", ovf, 0);
        check("ovf_rst_valid", evt_valid, 0);
        sb_on = 1'b1;
        evt_ready = 1'b1;
        acc_q.delete();
        cyc(60);
        exp_q.push_back({4'd1, 1'b1});
        expect_events("high_at_reset_evt");

        // Table-driven level vectors
        sw = '0;
        do_reset(2);
        acc_q.delete();
        foreach (vecs[v]) begin
            sw = vecs[v].sw;
            cyc(vecs[v].hold);
            check($sformatf("vec%0d_swd", v), swd, vecs[v].exp_swd);
        end
        cyc(20);
        acc_q.delete();

        // Randomized run against the reference model
        for (int it = 0; it < 40; it++) begin
            int hold;
            sw[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) sw[$urandom_range(0, N - 1)] ^= 1'b1;
            hold = $urandom_range(25, 70);
            repeat (hold) begin
                @(negedge clk);
                evt_ready = ($urandom_range(0, 3) != 0);
            end
        end
        evt_ready = 1'b1;
        cyc(80);
        sum = 0;
        for (int i = 0; i < N; i++) sum += out_rise[i] + out_fall[i];
        check("rand_drained", sum, 0);
        check("rand_no_ovf", ovf, 0);
        check("rand_idle", evt_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
